// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use detection and a long-latency write scoreboard for the EX stage.
// Define HAZARD_STATS_EN to add saturating stall-cycle and forward-event counters.
module hazard_forward_unit #(
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int NUM_REGS       = 32,
    parameter int MAX_LONG       = 4,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1),
    localparam int RW            = $clog2(NUM_REGS),
    localparam int CW            = $clog2(MAX_LONG + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0][RW-1:0]        ex_rs,
    input  logic [NUM_SRC-1:0]                ex_rs_used,
    input  logic [NUM_FWD_STAGES-1:0][RW-1:0] stage_rd,
    input  logic [NUM_FWD_STAGES-1:0]         stage_wen,
    input  logic                              id_valid,
    input  logic [NUM_SRC-1:0][RW-1:0]        id_rs,
    input  logic [NUM_SRC-1:0]                id_rs_used,
    input  logic                              ex_is_load,
    input  logic [RW-1:0]                     ex_rd,
    input  logic                              issue_long,
    input  logic [RW-1:0]                     issue_rd,
    input  logic                              long_done,
    input  logic [RW-1:0]                     long_done_rd,
    input  logic                              flush,
    output logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel,
    output logic                              stall,
    output logic [NUM_REGS-1:0]               sb_busy,
    output logic [CW-1:0]                     long_count
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                       stat_stall_cycles,
    output logic [31:0]                       stat_fwd_events
`endif
);

    logic any_blocked;
    logic waw_hazard;
    logic cap_hazard;
    logic accept;
    logic done_valid;

    // Walk from the farthest stage inward so the nearest matching stage overwrites.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[i] = '0;
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                if (ex_rs_used[i] && stage_wen[k] && (stage_rd[k] != '0) &&
                    (stage_rd[k] == ex_rs[i])) begin
                    fwd_sel[i] = SEL_W'(k + 1);
                end
            end
            if (rst) begin
                fwd_sel[i] = '0;
            end
        end
    end

    // A completing long op bypasses onto the MEM/WB path, so its rd is not blocking this cycle.
    always_comb begin
        any_blocked = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i] != '0)) begin
                if (ex_is_load && (ex_rd == id_rs[i])) begin
                    any_blocked = 1'b1;
                end
                if (sb_busy[id_rs[i]] && !(long_done && (long_done_rd == id_rs[i]))) begin
                    any_blocked = 1'b1;
                end
            end
        end
    end

    assign waw_hazard = issue_long && (issue_rd != '0) && sb_busy[issue_rd] &&
                        !(long_done && (long_done_rd == issue_rd));
    assign cap_hazard = issue_long && (long_count == CW'(MAX_LONG)) && !long_done;
    assign stall      = !rst && id_valid && !flush && (any_blocked || waw_hazard || cap_hazard);
    assign accept     = id_valid && issue_long && !stall && !flush;

    // Long ops with rd=0 never mark a busy bit, so their completion is recognised by rd alone.
    assign done_valid = long_done && ((long_done_rd == '0) || sb_busy[long_done_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy    <= '0;
            long_count <= '0;
        end else begin
            if (long_done) begin
                sb_busy[long_done_rd] <= 1'b0;
            end
            // Placed after the clear so a same-register set and clear leaves the bit set.
            if (accept && (issue_rd != '0)) begin
                sb_busy[issue_rd] <= 1'b1;
            end
            case ({accept, done_valid})
                2'b10: if (long_count != CW'(MAX_LONG)) long_count <= long_count + 1'b1;
                2'b01: if (long_count != '0) long_count <= long_count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_fwd_events   <= '0;
        end else begin
            if (stall && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
            end
            if ((|fwd_sel) && (stat_fwd_events != '1)) begin
                stat_fwd_events <= stat_fwd_events + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the EX-stage forwarding logic.
- Generates per-operand forward selects for the instruction in ID/EX across NUM_FWD_STAGES later stages, with nearest-stage priority.
- Detects load-use hazards for the instruction in IF/ID.
- Keeps a register scoreboard of outstanding long-latency writes (mul/div, cache-miss loads) and stalls dependent or conflicting issues.
- Sits between the decode/issue logic and the EX operand muxes.

Parameters:
- NUM_SRC, 2, source operands per instruction.
- NUM_FWD_STAGES, 2, stages forwarded from; index 0 = EX/MEM (nearest), 1 = MEM/WB, and so on.
- NUM_REGS, 32, architectural registers; index 0 is hardwired zero.
- MAX_LONG, 4, maximum outstanding long-latency ops.
- SEL_W, $clog2(NUM_FWD_STAGES+1), forward select width.

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- ex_rs in NUM_SRC x $clog2(NUM_REGS): source regs of the ID/EX instruction.
- ex_rs_used in NUM_SRC: operand actually read (lui/auipc/jal clear both; imm/load/jalr clear rs2).
- stage_rd in NUM_FWD_STAGES x $clog2(NUM_REGS): destination reg per later stage.
- stage_wen in NUM_FWD_STAGES: load_regfile per later stage.
- id_valid in 1: IF/ID holds a valid instruction.
- id_rs in NUM_SRC x $clog2(NUM_REGS): sources of the IF/ID instruction.
- id_rs_used in NUM_SRC: as ex_rs_used, for IF/ID.
- ex_is_load in 1: ID/EX instruction is a load.
- ex_rd in $clog2(NUM_REGS): ID/EX destination.
- issue_long in 1: IF/ID instruction is long-latency.
- issue_rd in $clog2(NUM_REGS): its destination.
- long_done in 1: a long op completes this cycle (result on the MEM/WB path).
- long_done_rd in $clog2(NUM_REGS): its destination.
- flush in 1: IF/ID squashed this cycle.
- fwd_sel out NUM_SRC x SEL_W: 0 = register file/ID/EX value; k+1 = stage k.
- stall out 1: hold PC and IF/ID, inject a bubble into ID/EX.
- sb_busy out NUM_REGS: scoreboard busy bits.
- long_count out $clog2(MAX_LONG+1): outstanding long ops.

Behaviour:
- Reset (rst high at a clk edge): sb_busy=0 and long_count=0. While rst is high, stall=0 and every fwd_sel=0.
- fwd_sel[i] is combinational. It equals k+1 for the smallest k with all of:
  - ex_rs_used[i]
  - stage_wen[k]
  - stage_rd[k]!=0
  - stage_rd[k]==ex_rs[i]
  Otherwise it is 0. Nearest stage always wins; both operands are evaluated independently.
- Operand blocking, for IF/ID operand i where id_rs_used[i] and id_rs[i]!=0:
  - Load-use blocked: ex_is_load and ex_rd==id_rs[i].
  - Scoreboard blocked: sb_busy[id_rs[i]] and NOT (long_done and long_done_rd==id_rs[i]). Completion is bypassed the same cycle.
- stall=1 when id_valid and !flush and any of:
  - any operand is blocked (load-use or scoreboard);
  - issue_long and issue_rd!=0 and sb_busy[issue_rd] and NOT same-cycle completion of that rd (WAW);
  - issue_long and long_count==MAX_LONG and !long_done (capacity).
- Accepted issue: id_valid and issue_long and !stall and !flush.
- Scoreboard update at each clk edge:
  - set sb_busy[issue_rd] on accepted issue with issue_rd!=0;
  - clear sb_busy[long_done_rd] on long_done.
  - Set and clear of the same reg in one cycle leaves it busy (set wins).
  - long_done for a non-busy reg is ignored.
  - sb_busy[0] is never set.
- long_count: +1 on accepted issue, -1 on long_done of a busy reg; both in one cycle leaves it unchanged.
  - Saturates at MAX_LONG and 0. Increment at MAX_LONG is impossible because that issue stalls.
  - Accepted issue with rd=0 still counts; its completion decrements via a zero-rd done pulse.
- Latency: stall and fwd_sel are zero-cycle combinational; scoreboard effects are visible the cycle after issue.
- flush does not alter outstanding scoreboard entries; in-flight long ops still complete.
- Reset mid-operation: all state cleared; stray long_done afterwards is ignored (count floors at 0).

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs stat_stall_cycles and stat_fwd_events, 32 bits each.
  - stat_stall_cycles increments each cycle stall=1.
  - stat_fwd_events increments each cycle any fwd_sel!=0, by 1 regardless of operand count.
  - Both saturate at all-ones and clear on rst.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forward priority: ex_rs[0]=5, stage_rd={5,5}, stage_wen={1,1} -> fwd_sel[0]=1. Then stage_wen={0,1} -> fwd_sel[0]=2. Then stage_rd={0,0} -> fwd_sel[0]=0.
- Unused operand: ex_rs[1]=7, ex_rs_used[1]=0, stage_rd[0]=7, stage_wen[0]=1 -> fwd_sel[1]=0.
- Load-use: ex_is_load=1, ex_rd=3, id_valid=1, id_rs[1]=3 used -> stall=1 for that cycle. Same with id_rs used=0, or with flush=1 -> stall=0.
- Scoreboard with bypass: accepted issue_long rd=9 -> next cycle sb_busy[9]=1, long_count=1.
  - A consumer reading x9 stalls until the long_done_rd=9 cycle, in which stall=0.
  - sb_busy[9]=0 and long_count=0 the following cycle.
- Capacity and WAW: four accepted long issues to x1..x4 -> long_count=4; a fifth issue to x6 stalls; an issue to x2 stalls (WAW). long_done x1 in the same cycle as the x6 issue -> x6 accepted, count stays 4.
- Reset: rst asserted with 3 outstanding -> next cycle sb_busy=0 and long_count=0. A following long_done is ignored; with HAZARD_STATS_EN, both stats read 0.
